unified_mem_arbiter: RTL and testbench

Arbitrates a single shared memory port between the instruction-fetch stage (read-only, 32-bit instructions) and the MEM stage (64-bit load/store) of the RISC-V core. It sits between `Program_Counter`/fetch logic and `Data_Memory` on one side and a single-ported unified memory on the other. It issues one transaction at a time, holds the pipeline through per-requester stall outputs, and returns data with a one-cycle done pulse. Data accesses have priority, with an optional starvation guard for fetch.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/unified_mem_arbiter_if.sv | 39 +++
 rtl/arb_starve_counter.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface unified_mem_arbiter_if;
    import mem_arb_pkg::*;

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_done;
    logic [ILEN-1:0] if_rdata;
    logic            if_stall;

    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_done;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_stall;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while fetch waits; flags when the limit is reached.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, data first.
// Define ARB_STARVE_GUARD_EN to let fetch through after STARVE_MAX consecutive data grants.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);

    arb_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            hi_q, hi_d;
    logic            if_done_q, if_done_d;
    logic            dm_done_q, dm_done_d;
    logic [ILEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic            fetch_first;
    logic            unused_if_lsb;

    assign unused_if_lsb = ^bus.if_addr[1:0];

`ifdef ARB_STARVE_GUARD_EN
    logic starve_hit;
    logic cnt_inc;
    logic cnt_clr;

    assign cnt_inc     = (state_q == IDLE) && (state_d == GNT_DM) && bus.if_req;
    assign cnt_clr     = (state_q == IDLE) && (state_d == GNT_IF);
    assign fetch_first = starve_hit & bus.if_req;

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .hit_o (starve_hit)
    );
`else
    logic unused_cfg;

    assign unused_cfg  = (STARVE_MAX == 0);
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        hi_d       = hi_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                // Request operands are captured here so the requester may change them afterwards.
                if (bus.dm_req && !fetch_first) begin
                    state_d = GNT_DM;
                    addr_d  = bus.dm_addr;
                    wdata_d = bus.dm_wdata;
                    we_d    = bus.dm_we;
                end else if (bus.if_req) begin
                    state_d = GNT_IF;
                    addr_d  = {bus.if_addr[XLEN-1:3], 3'b000};
                    we_d    = 1'b0;
                    hi_d    = bus.if_addr[2];
                end
            end
            GNT_IF: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = hi_q ? bus.mem_rdata[XLEN-1:ILEN] : bus.mem_rdata[ILEN-1:0];
                end
            end
            GNT_DM: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    dm_done_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            hi_q       <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            hi_q       <= hi_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = (state_q != IDLE) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;

    // Stalls are forced low while reset is held, even if a requester is already asserting.
    assign bus.if_stall  = bus.if_req & ~if_done_q & reset;
    assign bus.dm_stall  = bus.dm_req & ~dm_done_q & reset;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter; expected grant order follows ARB_STARVE_GUARD_EN.
module tb_unified_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(
        .STARVE_MAX (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after ack_delay extra cycles of mem_req.
    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end
    assign bus.mem_ack = bus.mem_req && (wait_cnt >= ack_delay);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
        reset = 1'b0;
        tick(); tick();
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
        checks++; if ({bus.if_done, bus.dm_done, bus.if_stall, bus.dm_stall} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {bus.if_done, bus.dm_done, bus.if_stall, bus.dm_stall}); end
        checks++; if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", bus.if_rdata, bus.dm_rdata); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        ack_delay = 0;
        bus.if_req = 1'b1; bus.if_addr = 64'h4; bus.mem_rdata = 64'h00A00093_00500013;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL fetch_grant got req=%0h we=%0h exp req=1 we=0", bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_addr !== 64'h0) begin failures++; $display("FAIL fetch_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.if_done !== 1'b0 || bus.if_stall !== 1'b1) begin failures++; $display("FAIL fetch_wait got done=%0h stall=%0h exp done=0 stall=1", bus.if_done, bus.if_stall); end
        tick();
        checks++; if (bus.if_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%0h exp=1", bus.if_done); end
        checks++; if (bus.if_rdata !== 32'h00A00093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00a00093", bus.if_rdata); end
        checks++; if (bus.if_stall !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_release got stall=%0h req=%0h exp 0/0", bus.if_stall, bus.mem_req); end
        bus.if_req = 1'b0;
        tick();
        checks++; if (bus.if_done !== 1'b0 || bus.if_rdata !== 32'h00A00093) begin failures++; $display("FAIL fetch_hold got done=%0h rdata=%h exp done=0 rdata=00a00093", bus.if_done, bus.if_rdata); end
    endtask

    task automatic test_priority();
        ack_delay = 0;
        bus.if_req = 1'b1; bus.if_addr = 64'h10;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h100;
        bus.mem_rdata = 64'h11223344_55667788;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h100) begin failures++; $display("FAIL prio_dm_first got req=%0h addr=%h exp req=1 addr=100", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.if_stall !== 1'b1 || bus.dm_stall !== 1'b1) begin failures++; $display("FAIL prio_stalls got if=%0h dm=%0h exp 1/1", bus.if_stall, bus.dm_stall); end
        tick();
        checks++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 64'h11223344_55667788) begin failures++; $display("FAIL prio_load got done=%0h rdata=%h exp done=1 rdata=1122334455667788", bus.dm_done, bus.dm_rdata); end
        checks++; if (bus.if_stall !== 1'b1 || bus.dm_stall !== 1'b0) begin failures++; $display("FAIL prio_stall_mid got if=%0h dm=%0h exp 1/0", bus.if_stall, bus.dm_stall); end
        bus.dm_req = 1'b0; bus.mem_rdata = 64'hCAFEF00D_12345678;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h10 || bus.if_stall !== 1'b1) begin failures++; $display("FAIL prio_if_second got req=%0h addr=%h stall=%0h exp 1/10/1", bus.mem_req, bus.mem_addr, bus.if_stall); end
        tick();
        checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h12345678) begin failures++; $display("FAIL prio_if_data got done=%0h rdata=%h exp done=1 rdata=12345678", bus.if_done, bus.if_rdata); end
        checks++; if (bus.if_stall !== 1'b0) begin failures++; $display("FAIL prio_if_stall got=%0h exp=0", bus.if_stall); end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        ack_delay = 2;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 64'h200; bus.dm_wdata = 64'hDEADBEEF;
        bus.mem_rdata = 64'hFFFFFFFF_FFFFFFFF;
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h200 || bus.mem_wdata !== 64'hDEADBEEF) begin failures++; $display("FAIL store_c1 got we=%0h addr=%h wdata=%h exp 1/200/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        bus.dm_addr = 64'h300; bus.dm_wdata = 64'h0;
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h200 || bus.mem_wdata !== 64'hDEADBEEF || bus.dm_done !== 1'b0) begin failures++; $display("FAIL store_c2 got we=%0h addr=%h wdata=%h done=%0h exp 1/200/deadbeef/0", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dm_done); end
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_ack !== 1'b1 || bus.dm_done !== 1'b0) begin failures++; $display("FAIL store_c3 got we=%0h ack=%0h done=%0h exp 1/1/0", bus.mem_we, bus.mem_ack, bus.dm_done); end
        tick();
        checks++; if (bus.dm_done !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL store_done got done=%0h we=%0h req=%0h exp 1/0/0", bus.dm_done, bus.mem_we, bus.mem_req); end
        checks++; if (bus.dm_rdata !== 64'h11223344_55667788) begin failures++; $display("FAIL store_rdata_hold got=%h exp=1122334455667788", bus.dm_rdata); end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; ack_delay = 0;
        tick();
        checks++; if (bus.dm_done !== 1'b0) begin failures++; $display("FAIL store_pulse got=%0h exp=0", bus.dm_done); end
    endtask

    task automatic test_reset_mid();
        ack_delay = 5;
        bus.if_req = 1'b1; bus.if_addr = 64'h8;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL midrst_grant got=%0h exp=1", bus.mem_req); end
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL midrst_async got=%0h exp=0", bus.mem_req); end
        tick();
        checks++; if (bus.if_done !== 1'b0 || bus.if_stall !== 1'b0 || bus.if_rdata !== 32'h0 || bus.dm_rdata !== 64'h0 || bus.mem_addr !== 64'h0) begin failures++; $display("FAIL midrst_held got done=%0h stall=%0h ird=%h drd=%h addr=%h exp all 0", bus.if_done, bus.if_stall, bus.if_rdata, bus.dm_rdata, bus.mem_addr); end
        bus.if_req = 1'b0; ack_delay = 0;
        reset = 1'b1;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_we !== 1'b0 || bus.if_stall !== 1'b0) begin failures++; $display("FAIL midrst_after got req=%0h done=%0h we=%0h stall=%0h exp all 0", bus.mem_req, bus.if_done, bus.mem_we, bus.if_stall); end
        tick();
        checks++; if (bus.if_done !== 1'b0) begin failures++; $display("FAIL midrst_nodone got=%0h exp=0", bus.if_done); end
    endtask

    task automatic test_starve();
        logic exp_if [6];
        logic got_if [6];
        int   ngrant  = 0;
        int   ndone   = 0;
        int   exp_done;
`ifdef ARB_STARVE_GUARD_EN
        exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_done = 2;
`else
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_done = 0;
`endif
        ack_delay = 0;
        bus.mem_rdata = 64'h0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h40;
        bus.if_req = 1'b1; bus.if_addr = 64'h80;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.if_done === 1'b1) ndone++;
            if (bus.mem_req === 1'b1 && ngrant < 6) begin
                got_if[ngrant] = (bus.mem_addr === 64'h80);
                ngrant++;
            end
        end
        checks++; if (ngrant !== 6) begin failures++; $display("FAIL starve_grants got=%0d exp=6", ngrant); end
        for (int g = 0; g < 6; g++) begin
            if (g < ngrant) begin
                checks++; if (got_if[g] !== exp_if[g]) begin failures++; $display("FAIL starve_order idx=%0d got_if=%0h exp_if=%0h", g, got_if[g], exp_if[g]); end
            end
        end
        checks++; if (ndone !== exp_done) begin failures++; $display("FAIL starve_if_done got=%0d exp=%0d", ndone, exp_done); end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_reset_mid();
        test_starve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
